// File: rtl/execute_muldiv_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide unit.
package execute_muldiv_pkg;

  localparam int MDU_DATA_WIDTH     = 32;
  localparam int MDU_REG_ADDR_WIDTH = 5;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

  function automatic logic is_div(input mdu_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  // Signedness of rs1 (rs2 = 0) or rs2 (rs2 = 1) for the given funct3.
  function automatic logic is_signed(input mdu_op_e op, input logic rs2);
    case (op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: return 1'b1;
      OP_MULHSU:                       return !rs2;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/execute_muldiv_if.sv
// Issue/result bundle between the execute stage and the multiply/divide unit.
interface execute_muldiv_if
  import execute_muldiv_pkg::*;
#(
  parameter int DATA_WIDTH     = MDU_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = MDU_REG_ADDR_WIDTH
);
  logic                      flush_i;
  logic                      start_i;
  logic [2:0]                op_i;
  logic [DATA_WIDTH-1:0]     a_i;
  logic [DATA_WIDTH-1:0]     b_i;
  logic [REG_ADDR_WIDTH-1:0] rd_i;
  logic                      busy_o;
  logic                      done_o;
  logic [DATA_WIDTH-1:0]     result_o;
  logic [REG_ADDR_WIDTH-1:0] rd_o;

  modport master (
    output flush_i, start_i, op_i, a_i, b_i, rd_i,
    input  busy_o, done_o, result_o, rd_o
  );

  modport slave (
    input  flush_i, start_i, op_i, a_i, b_i, rd_i,
    output busy_o, done_o, result_o, rd_o
  );
endinterface

// File: rtl/execute_muldiv_sign_fix.sv
// Conditional two's-complement: operand magnitude at capture, result sign at completion.
module execute_muldiv_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);
  assign result = negate ? (~value + WIDTH'(1)) : value;
endmodule

// File: rtl/execute_muldiv.sv
// Iterative RV32M multiply/divide: one radix-2 shift-add or restoring-divide step per clock.
module execute_muldiv
  import execute_muldiv_pkg::*;
#(
  parameter int DATA_WIDTH     = MDU_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = MDU_REG_ADDR_WIDTH
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  execute_muldiv_if.slave bus
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] MIN_INT = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  mdu_state_e                state_reg, state_next;
  mdu_op_e                   op_reg, op_next, op_in;
  logic [CW-1:0]             cnt_reg, cnt_next;
  logic [REG_ADDR_WIDTH-1:0] rd_reg;
  logic                      neg_q_reg, neg_q_next, neg_r_reg, neg_r_next;
  logic [DATA_WIDTH-1:0]     hi_reg, hi_next, lo_reg, lo_next, b_reg, b_next, result_reg;
  logic                      accept, a_neg, b_neg, div_by_zero, div_ovf;
  logic [DATA_WIDTH-1:0]     a_mag, b_mag, quot_fix, rem_fix, result_sel;
  logic [2*DATA_WIDTH-1:0]   prod_fix;
  logic [DATA_WIDTH:0]       mul_sum, mul_part, div_shift, div_diff;

  assign op_in       = mdu_op_e'(bus.op_i);
  assign accept      = (state_reg == IDLE) && bus.start_i && !bus.flush_i;
  assign a_neg       = is_signed(op_in, 1'b0) && bus.a_i[DATA_WIDTH-1];
  assign b_neg       = is_signed(op_in, 1'b1) && bus.b_i[DATA_WIDTH-1];
  assign div_by_zero = is_div(op_in) && (bus.b_i == '0);
  assign div_ovf     = (op_in == OP_DIV || op_in == OP_REM) && (bus.a_i == MIN_INT) && (bus.b_i == '1);

  execute_muldiv_sign_fix #(.WIDTH(DATA_WIDTH)) u_abs_a (.value(bus.a_i), .negate(a_neg), .result(a_mag));
  execute_muldiv_sign_fix #(.WIDTH(DATA_WIDTH)) u_abs_b (.value(bus.b_i), .negate(b_neg), .result(b_mag));

  // hi:lo holds product (mul) or remainder:quotient (div); the guard bit catches carry/borrow.
  assign mul_sum   = {1'b0, hi_reg} + {1'b0, b_reg};
  assign mul_part  = lo_reg[0] ? mul_sum : {1'b0, hi_reg};
  assign div_shift = {hi_reg, lo_reg[DATA_WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, b_reg};

  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    cnt_next   = cnt_reg;
    neg_q_next = neg_q_reg;
    neg_r_next = neg_r_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    b_next     = b_reg;
    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          op_next    = op_in;
          cnt_next   = '0;
          hi_next    = '0;
          lo_next    = a_mag;
          b_next     = b_mag;
          neg_q_next = a_neg ^ b_neg;
          neg_r_next = a_neg;
          state_next = CALC;
          if (div_by_zero) begin
            hi_next    = bus.a_i;
            lo_next    = '1;
            neg_q_next = 1'b0;
            neg_r_next = 1'b0;
            state_next = DONE;
          end else if (div_ovf) begin
            hi_next    = '0;
            lo_next    = bus.a_i;
            neg_q_next = 1'b0;
            neg_r_next = 1'b0;
            state_next = DONE;
          end
        end
      end
      CALC: begin
        cnt_next = cnt_reg + CW'(1);
        if (is_div(op_reg)) begin
          if (!div_diff[DATA_WIDTH]) begin
            hi_next = div_diff[DATA_WIDTH-1:0];
            lo_next = {lo_reg[DATA_WIDTH-2:0], 1'b1};
          end else begin
            hi_next = div_shift[DATA_WIDTH-1:0];
            lo_next = {lo_reg[DATA_WIDTH-2:0], 1'b0};
          end
        end else begin
          hi_next = mul_part[DATA_WIDTH:1];
          lo_next = {mul_part[0], lo_reg[DATA_WIDTH-1:1]};
        end
        if (bus.flush_i)                          state_next = IDLE;
        else if (cnt_reg == CW'(DATA_WIDTH - 1))  state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Result is formed from the values entering DONE so it is valid alongside done_o.
  execute_muldiv_sign_fix #(.WIDTH(2*DATA_WIDTH)) u_fix_prod (.value({hi_next, lo_next}), .negate(neg_q_next), .result(prod_fix));
  execute_muldiv_sign_fix #(.WIDTH(DATA_WIDTH))   u_fix_quot (.value(lo_next), .negate(neg_q_next), .result(quot_fix));
  execute_muldiv_sign_fix #(.WIDTH(DATA_WIDTH))   u_fix_rem  (.value(hi_next), .negate(neg_r_next), .result(rem_fix));

  always_comb begin
    result_sel = rem_fix;
    case (op_next)
      OP_MUL:                       result_sel = prod_fix[DATA_WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result_sel = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
      OP_DIV, OP_DIVU:              result_sel = quot_fix;
      default:                      result_sel = rem_fix;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg  <= IDLE;
      op_reg     <= OP_MUL;
      cnt_reg    <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      b_reg      <= '0;
      rd_reg     <= '0;
      result_reg <= '0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      cnt_reg   <= cnt_next;
      neg_q_reg <= neg_q_next;
      neg_r_reg <= neg_r_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      b_reg     <= b_next;
      if (accept)             rd_reg     <= bus.rd_i;
      if (state_next == DONE) result_reg <= result_sel;
    end
  end

  assign bus.busy_o   = accept || (state_reg == CALC);
  assign bus.done_o   = (state_reg == DONE) && !bus.flush_i;
  assign bus.result_o = result_reg;
  assign bus.rd_o     = rd_reg;

endmodule

// File: tb/tb_execute_muldiv.sv
// Self-checking bench: directed vector table, flush/reset sequences, randomized ops vs arithmetic model.
module tb_execute_muldiv;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_vec  = 0;
  int   n_err  = 0;
  int   n_chk  = 0;

  execute_muldiv_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) m ();

  execute_muldiv #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic plus the RISC-V divide corner rules.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    r  = '0;
    case (op)
      3'd0: begin p = sa * sb; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: if (b == 0) r = '1; else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
            else begin p = sa / sb; r = p[31:0]; end
      3'd5: if (b == 0) r = '1; else begin p = ua / ub; r = p[31:0]; end
      3'd6: if (b == 0) r = a; else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
            else begin p = sa % sb; r = p[31:0]; end
      default: if (b == 0) r = a; else begin p = ua % ub; r = p[31:0]; end
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] res, output int lat);
    int busy_cycles;
    bit got_done;
    @(negedge clk);
    check("done_pulse_width", 64'(m.done_o), 64'(0));
    m.flush_i = 1'b0; m.start_i = 1'b1; m.op_i = op; m.a_i = a; m.b_i = b; m.rd_i = rd;
    #1;
    check("busy_issue", 64'(m.busy_o), 64'(1));
    busy_cycles = 1;
    got_done    = 1'b0;
    lat         = 0;
    while (!got_done && lat < 100) begin
      @(negedge clk);
      lat++;
      if (m.done_o) got_done = 1'b1;
      else begin
        if (m.busy_o) busy_cycles++;
        m.op_i = 3'($urandom); m.a_i = $urandom; m.b_i = $urandom; m.rd_i = 5'($urandom);
      end
    end
    n_vec++;
    if (!got_done) check("done_timeout", 64'(m.done_o), 64'(1));
    res = m.result_o;
    check("rd_out", 64'(m.rd_o), 64'(rd));
    check("busy_at_done", 64'(m.busy_o), 64'(0));
    check("busy_cycles", 64'(busy_cycles), 64'(lat));
    m.start_i = 1'b0;
    $display("op=%0d a=%h b=%h rd=%0d result=%h rd_o=%0d lat=%0d", op, a, b, rd, res, m.rd_o, lat);
  endtask

  initial begin
    vec_t        vecs[20];
    logic [31:0] res, ra, rb;
    logic [2:0]  rop;
    int          lat, quiet;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 33};
    vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 33};
    vecs[2]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'h0000_0000, 33};
    vecs[3]  = '{3'd4, 32'hFFFF_FFEC,  32'd6,         5'd4,  32'hFFFF_FFFD, 33};
    vecs[4]  = '{3'd6, 32'hFFFF_FFEC,  32'd6,         5'd5,  32'hFFFF_FFFE, 33};
    vecs[5]  = '{3'd5, 32'd20,         32'd6,         5'd6,  32'd3,         33};
    vecs[6]  = '{3'd4, 32'd5,          32'd0,         5'd7,  32'hFFFF_FFFF, 1};
    vecs[7]  = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd8,  32'h0000_0000, 1};
    vecs[8]  = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd9,  32'h8000_0000, 1};
    vecs[9]  = '{3'd7, 32'd5,          32'd0,         5'd10, 32'd5,         1};
    vecs[10] = '{3'd6, 32'hFFFF_FFF9,  32'd0,         5'd11, 32'hFFFF_FFF9, 1};
    vecs[11] = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd12, 32'hFFFF_FFFF, 33};
    vecs[12] = '{3'd1, 32'h8000_0000,  32'h8000_0000, 5'd13, 32'h4000_0000, 33};
    vecs[13] = '{3'd0, 32'h8000_0000,  32'h8000_0000, 5'd14, 32'h0000_0000, 33};
    vecs[14] = '{3'd4, 32'd7,          32'hFFFF_FFFD, 5'd15, 32'hFFFF_FFFE, 33};
    vecs[15] = '{3'd6, 32'd7,          32'hFFFF_FFFD, 5'd16, 32'd1,         33};
    vecs[16] = '{3'd7, 32'hFFFF_FFFF,  32'h10,        5'd17, 32'hF,         33};
    vecs[17] = '{3'd5, 32'hFFFF_FFFF,  32'd1,         5'd18, 32'hFFFF_FFFF, 33};
    vecs[18] = '{3'd5, 32'd3,          32'd0,         5'd19, 32'hFFFF_FFFF, 1};
    vecs[19] = '{3'd2, 32'hFFFF_FFFE,  32'd3,         5'd20, 32'hFFFF_FFFF, 33};

    rst_n = 1'b0;
    m.flush_i = 1'b0; m.start_i = 1'b0; m.op_i = '0; m.a_i = '0; m.b_i = '0; m.rd_i = '0;
    #12;
    check("reset_busy",   64'(m.busy_o),   64'(0));
    check("reset_done",   64'(m.done_o),   64'(0));
    check("reset_result", 64'(m.result_o), 64'(0));
    check("reset_rd",     64'(m.rd_o),     64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, res, lat);
      check($sformatf("vec%0d_result", i), 64'(res), 64'(vecs[i].exp));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
    end

    // Flush at CALC step 10, with start still high: nothing accepted or completed afterwards.
    @(negedge clk);
    m.op_i = 3'd4; m.a_i = 32'd1000; m.b_i = 32'd7; m.rd_i = 5'd25; m.start_i = 1'b1;
    repeat (11) @(negedge clk);
    m.flush_i = 1'b1;
    #1;
    check("busy_calc_flush", 64'(m.busy_o), 64'(1));
    @(negedge clk);
    check("flush_no_done",  64'(m.done_o), 64'(0));
    check("flush_busy_low", 64'(m.busy_o), 64'(0));
    m.start_i = 1'b0; m.flush_i = 1'b0;
    n_vec++;
    $display("flush at step 10: done_o=%0d busy_o=%0d", m.done_o, m.busy_o);
    quiet = 0;
    repeat (40) begin
      @(negedge clk);
      if (m.done_o || m.busy_o) quiet++;
    end
    check("flush_quiet", 64'(quiet), 64'(0));
    run_op(3'd6, 32'hFFFF_FC18, 32'd7, 5'd26, res, lat);
    check("after_flush_result", 64'(res), 64'(ref_model(3'd6, 32'hFFFF_FC18, 32'd7)));

    // Flush arriving during DONE suppresses the pulse.
    @(negedge clk);
    m.op_i = 3'd5; m.a_i = 32'd100; m.b_i = 32'd7; m.rd_i = 5'd24; m.start_i = 1'b1;
    repeat (33) @(negedge clk);
    m.start_i = 1'b0; m.flush_i = 1'b1;
    #1;
    check("flush_done_suppressed", 64'(m.done_o), 64'(0));
    n_vec++;
    $display("flush in DONE: done_o=%0d", m.done_o);
    @(negedge clk);
    m.flush_i = 1'b0;

    // Async reset mid-CALC, then back-to-back ops.
    @(negedge clk);
    m.op_i = 3'd0; m.a_i = 32'd1234; m.b_i = 32'd99; m.rd_i = 5'd21; m.start_i = 1'b1;
    repeat (10) @(negedge clk);
    #2;
    m.start_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_busy",   64'(m.busy_o),   64'(0));
    check("midrst_done",   64'(m.done_o),   64'(0));
    check("midrst_result", 64'(m.result_o), 64'(0));
    check("midrst_rd",     64'(m.rd_o),     64'(0));
    n_vec++;
    $display("reset mid-CALC: busy_o=%0d result_o=%h rd_o=%0d", m.busy_o, m.result_o, m.rd_o);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 0;
    repeat (40) begin
      @(negedge clk);
      if (m.done_o || m.busy_o) quiet++;
    end
    check("midrst_quiet", 64'(quiet), 64'(0));
    run_op(3'd0, 32'hFFFF_FF85, 32'd321, 5'd22, res, lat);
    check("b2b_mul_result", 64'(res), 64'(ref_model(3'd0, 32'hFFFF_FF85, 32'd321)));
    run_op(3'd5, 32'd1_000_000, 32'd37, 5'd23, res, lat);
    check("b2b_divu_result", 64'(res), 64'(ref_model(3'd5, 32'd1_000_000, 32'd37)));
    repeat (5) @(negedge clk);
    check("result_hold", 64'(m.result_o), 64'(res));
    check("rd_hold",     64'(m.rd_o),     64'(23));

    // Randomized ops, biased toward the divide corner cases.
    for (int i = 0; i < 200; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 6))
        0: rb = '0;
        1: rb = '1;
        2: begin ra = 32'h8000_0000; rb = '1; end
        3: begin ra = $urandom_range(0, 60); rb = $urandom_range(1, 9); end
        4: ra = 32'h8000_0000;
        default: ;
      endcase
      run_op(rop, ra, rb, 5'($urandom), res, lat);
      check($sformatf("rand%0d_result", i), 64'(res), 64'(ref_model(rop, ra, rb)));
      check($sformatf("rand%0d_latency", i), 64'(lat), 64'(ref_lat(rop, ra, rb)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
